// File: rtl/axi_vga_frame_sequencer.sv
// Frame scheduler for the VGA read path: one frame of 4 KiB-safe AXI bursts per vsync, FIFO-space
// throttling and double-buffer page flip. Optional stats counters enabled by AXI_VGA_SEQ_STATS_EN.
module axi_vga_frame_sequencer #(
    parameter int unsigned AXIAddrWidth   = 64,
    parameter int unsigned AXIDataWidth   = 64,
    parameter int unsigned FifoDepth      = 256,
    parameter int unsigned LvlWidth       = 9,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [AXIAddrWidth-1:0] buf0_addr_i,
    input  logic [AXIAddrWidth-1:0] buf1_addr_i,
    input  logic [31:0]             frame_size_i,
    input  logic [7:0]              burst_len_i,
    input  logic                    flip_req_i,
    input  logic                    frame_start_i,
    input  logic [LvlWidth-1:0]     fifo_level_i,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    output logic [AXIAddrWidth-1:0] req_addr_o,
    output logic [7:0]              req_len_o,
    input  logic                    burst_done_i,
    output logic                    active_buf_o,
    output logic                    flip_ack_o,
    output logic                    busy_o,
    output logic                    frame_late_o,
    output logic [15:0]             frame_cnt_o,
    output logic [15:0]             late_cnt_o,
    output logic [1:0]              dbg_state_o
);

    localparam int unsigned BpbShift = $clog2(AXIDataWidth / 8);
    localparam int unsigned PtrW     = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned OutW     = $clog2(MaxOutstanding + 1);
    localparam int unsigned BeatW    = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic                    late_pend_q, late_pend_d;
    logic                    flip_pend_q, flip_pend_d;
    logic                    active_buf_q, active_buf_d;
    logic                    flip_ack_q, flip_ack_d;
    logic                    frame_late_q, frame_late_d;
    logic [AXIAddrWidth-1:0] addr_q, addr_d;
    logic [31:0]             remaining_q, remaining_d;
    logic                    req_valid_q, req_valid_d;
    logic [7:0]              req_len_q, req_len_d;
    logic [OutW-1:0]         outstanding_q, outstanding_d;
    logic [LvlWidth-1:0]     inflight_q, inflight_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BeatW-1:0]        len_fifo_q [MaxOutstanding];
    logic [BeatW-1:0]        len_fifo_d [MaxOutstanding];

    logic                    hs, pop;
    logic [BeatW-1:0]        req_beats, beats;
    logic [12:0]             to_4k_bytes, to_4k_beats;
    logic signed [LvlWidth:0] space;
    logic                    space_ok;

    // Handshake: req_valid_o is registered; once high, req_addr_o/req_len_o stay frozen and
    // valid stays high until the cycle req_ready_i is seen, after which it drops for at least one cycle.
    assign hs        = req_valid_q & req_ready_i;
    assign pop       = burst_done_i & (outstanding_q != '0);
    assign req_beats = {1'b0, req_len_q} + 9'd1;

    // Beats of the next burst: limited by burst_len, what is left of the frame and the 4 KiB page.
    always_comb begin
        to_4k_bytes = 13'h1000 - {1'b0, addr_q[11:0]};
        to_4k_beats = to_4k_bytes >> BpbShift;
        beats       = {1'b0, burst_len_i} + 9'd1;
        if (remaining_q < 32'(beats)) beats = remaining_q[BeatW-1:0];
        if (32'(to_4k_beats) < 32'(beats)) beats = to_4k_beats[BeatW-1:0];
        space    = $signed((LvlWidth+1)'(FifoDepth)) - $signed({1'b0, fifo_level_i})
                   - $signed({1'b0, inflight_q});
        space_ok = !space[LvlWidth] && (32'(space[LvlWidth-1:0]) >= 32'(beats));
    end

    always_comb begin
        state_d      = state_q;
        late_pend_d  = late_pend_q;
        flip_pend_d  = flip_pend_q | flip_req_i;
        active_buf_d = active_buf_q;
        flip_ack_d   = 1'b0;
        frame_late_d = 1'b0;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        req_valid_d  = req_valid_q;
        req_len_d    = req_len_q;

        if (hs) begin
            req_valid_d = 1'b0;
            addr_d      = addr_q + (AXIAddrWidth'(req_beats) << BpbShift);
            remaining_d = remaining_q - 32'(req_beats);
        end

        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!enable_i) begin
                    state_d     = ST_DRAIN;
                    late_pend_d = 1'b0;
                    flip_pend_d = 1'b0;
                end else if (frame_start_i || late_pend_q) begin
                    state_d     = ST_ISSUE;
                    late_pend_d = 1'b0;
                    remaining_d = frame_size_i;
                    if (flip_pend_q || flip_req_i) begin
                        active_buf_d = ~active_buf_q;
                        flip_ack_d   = 1'b1;
                        flip_pend_d  = 1'b0;
                    end
                    addr_d = active_buf_d ? buf1_addr_i : buf0_addr_i;
                end
            end
            ST_ISSUE: begin
                if (!enable_i) begin
                    // A request already on the bus stays valid until accepted.
                    state_d     = ST_DRAIN;
                    late_pend_d = 1'b0;
                    flip_pend_d = 1'b0;
                end else begin
                    if (frame_start_i) begin
                        late_pend_d  = 1'b1;
                        frame_late_d = 1'b1;
                    end
                    if (!req_valid_q) begin
                        if (remaining_q == '0) begin
                            state_d = ST_WAIT;
                        end else if (outstanding_q < OutW'(MaxOutstanding) && space_ok) begin
                            req_valid_d = 1'b1;
                            req_len_d   = 8'(beats - 9'd1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!req_valid_q && outstanding_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst-length FIFO lets each burst_done_i retire exactly the beats of the oldest burst.
    always_comb begin
        len_fifo_d    = len_fifo_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        inflight_d    = inflight_q;
        if (hs) begin
            len_fifo_d[wr_ptr_q] = req_beats;
            wr_ptr_d      = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            outstanding_d = outstanding_d + OutW'(1);
            inflight_d    = inflight_d + LvlWidth'(req_beats);
        end
        if (pop) begin
            rd_ptr_d      = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            outstanding_d = outstanding_d - OutW'(1);
            inflight_d    = inflight_d - LvlWidth'(len_fifo_q[rd_ptr_q]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            late_pend_q   <= 1'b0;
            flip_pend_q   <= 1'b0;
            active_buf_q  <= 1'b0;
            flip_ack_q    <= 1'b0;
            frame_late_q  <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            req_valid_q   <= 1'b0;
            req_len_q     <= '0;
            outstanding_q <= '0;
            inflight_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            len_fifo_q    <= '{default: '0};
        end else begin
            state_q       <= state_d;
            late_pend_q   <= late_pend_d;
            flip_pend_q   <= flip_pend_d;
            active_buf_q  <= active_buf_d;
            flip_ack_q    <= flip_ack_d;
            frame_late_q  <= frame_late_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            req_valid_q   <= req_valid_d;
            req_len_q     <= req_len_d;
            outstanding_q <= outstanding_d;
            inflight_q    <= inflight_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            len_fifo_q    <= len_fifo_d;
        end
    end

    assign req_valid_o  = req_valid_q;
    assign req_addr_o   = addr_q;
    assign req_len_o    = req_len_q;
    assign active_buf_o = active_buf_q;
    assign flip_ack_o   = flip_ack_q;
    assign frame_late_o = frame_late_q;
    assign busy_o       = (state_q != ST_IDLE) || (outstanding_q != '0);
    assign dbg_state_o  = state_q;

`ifdef AXI_VGA_SEQ_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] late_cnt_q, late_cnt_d;
    logic        frame_evt;

    always_comb begin
        frame_evt   = (state_q == ST_WAIT) && enable_i && (frame_start_i || late_pend_q);
        frame_cnt_d = frame_cnt_q + (frame_evt ? 16'd1 : 16'd0);
        late_cnt_d  = late_cnt_q;
        if (frame_late_d && late_cnt_q != 16'hFFFF) late_cnt_d = late_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            late_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            late_cnt_q  <= late_cnt_d;
        end
    end

    assign frame_cnt_o = frame_cnt_q;
    assign late_cnt_o  = late_cnt_q;
`else
    assign frame_cnt_o = '0;
    assign late_cnt_o  = '0;
`endif

endmodule
